// File: rtl/qch_pkg.sv
// Shared types and limits for the Q-channel fan-out controller.
package qch_pkg;

    // Largest number of downstream device channels one controller serves.
    localparam int QCH_MAX_CH = 16;

    // Controller sequence states.
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_REQ      = 3'd1,
        ST_STOPPED  = 3'd2,
        ST_RESTORE  = 3'd3,
        ST_EXIT     = 3'd4,
        ST_ROLLBACK = 3'd5,
        ST_DENIED   = 3'd6
    } qch_state_e;

endpackage

// File: rtl/qchannel_fanout_if.sv
// Upstream Q-channel plus per-device fan-out signals of the controller.
// The controller connects through 'slave' (it is the device side of the
// upstream Q-channel); the environment driving it uses 'master'.
interface qchannel_fanout_if #(
    parameter int N_CH = 4
);
    logic            qreqn_i;
    logic            qacceptn_o;
    logic            qdeny_o;
    logic [N_CH-1:0] ch_en_i;
    logic [N_CH-1:0] dev_qreqn_o;
    logic [N_CH-1:0] dev_qacceptn_i;
    logic [N_CH-1:0] dev_qdeny_i;
    logic            pr_restore_o;
    logic            timeout_o;

    modport slave (
        input  qreqn_i, ch_en_i, dev_qacceptn_i, dev_qdeny_i,
        output qacceptn_o, qdeny_o, dev_qreqn_o, pr_restore_o, timeout_o
    );

    modport master (
        output qreqn_i, ch_en_i, dev_qacceptn_i, dev_qdeny_i,
        input  qacceptn_o, qdeny_o, dev_qreqn_o, pr_restore_o, timeout_o
    );
endinterface

// File: rtl/qch_status_agg.sv
// Masked reduction of downstream Q-channel status. Disabled channels count
// as having accepted, as running and as not denying.
module qch_status_agg #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] en_i,
    input  logic [N_CH-1:0] qacceptn_i,
    input  logic [N_CH-1:0] qdeny_i,
    output logic            all_accepted_o,
    output logic            all_running_o,
    output logic            any_deny_o
);
    logic [N_CH-1:0] accepted_ok;
    logic [N_CH-1:0] running_ok;
    logic [N_CH-1:0] deny_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign accepted_ok[gi] = !en_i[gi] || (!qacceptn_i[gi] && !qdeny_i[gi]);
            assign running_ok[gi]  = !en_i[gi] || ( qacceptn_i[gi] && !qdeny_i[gi]);
            assign deny_hit[gi]    =  en_i[gi] &&   qdeny_i[gi];
        end
    endgenerate

    assign all_accepted_o = &accepted_ok;
    assign all_running_o  = &running_ok;
    assign any_deny_o     = |deny_hit;
endmodule

// File: rtl/qchannel_fanout.sv
// Fans one upstream Q-channel out to N_CH device Q-channels: collects all
// device accepts before accepting upstream, rolls back and denies on any
// device deny or on timeout, and strobes a retention restore on wake-up.
// Every output is a flop computed from the next state.
module qchannel_fanout
    import qch_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int RESTORE_CYCLES = 2,
    parameter int TIMEOUT        = 64
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    qchannel_fanout_if.slave   bus
);
    localparam int              TW      = $clog2(TIMEOUT + 1) + 1;
    localparam logic [TW-1:0]   TO_VAL  = TW'(TIMEOUT);
    localparam logic [3:0]      RC_LAST = 4'(RESTORE_CYCLES - 1);

    generate
        if (N_CH < 1 || N_CH > QCH_MAX_CH) begin : g_bad_n_ch
            $error("qchannel_fanout: N_CH out of range");
        end
    endgenerate

    qch_state_e      state_q, state_d;
    logic [N_CH-1:0] en_q, en_d;
    logic [TW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]      rcnt_q, rcnt_d;
    logic            qacceptn_q, qacceptn_d;
    logic            qdeny_q, qdeny_d;
    logic [N_CH-1:0] dev_qreqn_q, dev_qreqn_d;
    logic            pr_restore_q, pr_restore_d;
    logic            timeout_q, timeout_d;

    logic all_accepted, all_running, any_deny, exit_done, timeout_hit;

    qch_status_agg #(.N_CH(N_CH)) u_agg (
        .en_i           (en_q),
        .qacceptn_i     (bus.dev_qacceptn_i),
        .qdeny_i        (bus.dev_qdeny_i),
        .all_accepted_o (all_accepted),
        .all_running_o  (all_running),
        .any_deny_o     (any_deny)
    );

    // Wake-up only needs every enabled device to have raised its accept.
    assign exit_done   = &(~en_q | bus.dev_qacceptn_i);
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + TW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc >= TO_VAL);

    // Next-state, counters and next output values.
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!bus.qreqn_i) begin
                    state_d = ST_REQ;
                    en_d    = bus.ch_en_i;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                // Deny beats accept; accepts collected in the final allowed
                // cycle still beat the timeout.
                if (any_deny) begin
                    state_d = ST_ROLLBACK;
                end else if (all_accepted) begin
                    state_d = ST_STOPPED;
                end else if (timeout_hit) begin
                    state_d   = ST_ROLLBACK;
                    timeout_d = 1'b1;
                end
            end
            ST_STOPPED: begin
                if (bus.qreqn_i) begin
                    state_d = ST_RESTORE;
                    rcnt_d  = '0;
                end
            end
            ST_RESTORE: begin
                if (rcnt_q == RC_LAST) state_d = ST_EXIT;
                else                   rcnt_d  = rcnt_q + 4'd1;
            end
            ST_EXIT:     if (exit_done)     state_d = ST_RUN;
            ST_ROLLBACK: if (all_running)   state_d = ST_DENIED;
            ST_DENIED:   if (bus.qreqn_i)   state_d = ST_RUN;
            default:                        state_d = ST_RUN;
        endcase

        qacceptn_d   = !(state_d inside {ST_STOPPED, ST_RESTORE, ST_EXIT});
        qdeny_d      = (state_d == ST_DENIED);
        pr_restore_d = (state_d == ST_RESTORE);
        dev_qreqn_d  = (state_d inside {ST_REQ, ST_STOPPED, ST_RESTORE}) ? ~en_d : '1;
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_RUN;
            en_q         <= '0;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            qacceptn_q   <= 1'b1;
            qdeny_q      <= 1'b0;
            dev_qreqn_q  <= '1;
            pr_restore_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            qacceptn_q   <= qacceptn_d;
            qdeny_q      <= qdeny_d;
            dev_qreqn_q  <= dev_qreqn_d;
            pr_restore_q <= pr_restore_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.qacceptn_o   = qacceptn_q;
    assign bus.qdeny_o      = qdeny_q;
    assign bus.dev_qreqn_o  = dev_qreqn_q;
    assign bus.pr_restore_o = pr_restore_q;
    assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_qchannel_fanout.sv
// Bench for qchannel_fanout: directed vector table, hand sequences for the
// timeout and mid-sequence reset, then random traffic against a model.
module tb_qchannel_fanout;
    localparam int N_CH = 4;
    localparam int RC   = 2;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    qchannel_fanout_if #(.N_CH(N_CH)) bus ();

    qchannel_fanout #(.N_CH(N_CH), .RESTORE_CYCLES(RC), .TIMEOUT(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       qreqn;
        logic [3:0] en, acc, dn;
        logic       qa, qd;
        logic [3:0] dq;
        logic       pr, to;
    } vec_t;
    vec_t vecs[$];

    // Model phases
    localparam int P_RUN = 0, P_REQ = 1, P_STOP = 2, P_RES = 3, P_EXIT = 4, P_RB = 5, P_DEN = 6;
    int         m_phase, m_age, m_left;
    logic [3:0] m_en;
    logic       m_to;
    logic       d_qreqn;
    logic [3:0] d_en, d_acc, d_dn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic qa, input logic qd,
                             input logic [3:0] dq, input logic pr, input logic to);
        check({tag, ".qacceptn"},   32'(bus.qacceptn_o),   32'(qa));
        check({tag, ".qdeny"},      32'(bus.qdeny_o),      32'(qd));
        check({tag, ".dev_qreqn"},  32'(bus.dev_qreqn_o),  32'(dq));
        check({tag, ".pr_restore"}, 32'(bus.pr_restore_o), 32'(pr));
        check({tag, ".timeout"},    32'(bus.timeout_o),    32'(to));
    endtask

    task automatic drive(input logic q, input logic [3:0] en, input logic [3:0] acc, input logic [3:0] dn);
        d_qreqn = q; d_en = en; d_acc = acc; d_dn = dn;
        bus.qreqn_i = q; bus.ch_en_i = en; bus.dev_qacceptn_i = acc; bus.dev_qdeny_i = dn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic q, input logic [3:0] en, input logic [3:0] acc, input logic [3:0] dn,
                       input logic qa, input logic qd, input logic [3:0] dq, input logic pr, input logic to);
        vec_t v;
        v.qreqn = q; v.en = en; v.acc = acc; v.dn = dn;
        v.qa = qa; v.qd = qd; v.dq = dq; v.pr = pr; v.to = to;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Model of one rising edge, written from the sequence rules.
    task automatic model_step();
        m_to = 1'b0;
        case (m_phase)
            P_RUN:  if (!d_qreqn) begin m_en = d_en; m_age = 0; m_phase = P_REQ; end
            P_REQ: begin
                m_age++;
                if ((m_en & d_dn) != 4'h0)                 m_phase = P_RB;
                else if ((m_en & (d_acc | d_dn)) == 4'h0)  m_phase = P_STOP;
                else if (m_age >= TO) begin m_phase = P_RB; m_to = 1'b1; end
            end
            P_RB:   if ((m_en & ~d_acc) == 4'h0 && (m_en & d_dn) == 4'h0) m_phase = P_DEN;
            P_DEN:  if (d_qreqn) m_phase = P_RUN;
            P_STOP: if (d_qreqn) begin m_phase = P_RES; m_left = RC; end
            P_RES:  begin m_left--; if (m_left == 0) m_phase = P_EXIT; end
            P_EXIT: if ((m_en & ~d_acc) == 4'h0) m_phase = P_RUN;
            default: m_phase = P_RUN;
        endcase
    endtask

    initial begin
        logic q;
        logic [3:0] acc, dn;
        drive(1'b1, 4'hF, 4'hF, 4'h0);
        rst_n = 1'b0;
        #12;
        check_all("reset", 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // qreqn en acc dn | qa qd dq pr to
        add(1, 4'hF, 4'hF, 4'h0,  1, 0, 4'hF, 0, 0); // RUN idle
        add(0, 4'hF, 4'hF, 4'h0,  1, 0, 4'h0, 0, 0); // ->REQ
        add(0, 4'hF, 4'hF, 4'h0,  1, 0, 4'h0, 0, 0);
        add(0, 4'hF, 4'hF, 4'h0,  1, 0, 4'h0, 0, 0);
        add(0, 4'hF, 4'h0, 4'h0,  0, 0, 4'h0, 0, 0); // all accept ->STOPPED
        add(0, 4'hF, 4'h0, 4'h0,  0, 0, 4'h0, 0, 0);
        add(1, 4'hF, 4'h0, 4'h0,  0, 0, 4'h0, 1, 0); // ->RESTORE
        add(1, 4'hF, 4'h0, 4'h0,  0, 0, 4'h0, 1, 0);
        add(1, 4'hF, 4'h0, 4'h0,  0, 0, 4'hF, 0, 0); // ->EXIT
        add(1, 4'hF, 4'hF, 4'h0,  1, 0, 4'hF, 0, 0); // ->RUN
        add(0, 4'hF, 4'hF, 4'h0,  1, 0, 4'h0, 0, 0); // ->REQ
        add(0, 4'hF, 4'h0, 4'h4,  1, 0, 4'hF, 0, 0); // deny beats accept ->ROLLBACK
        add(0, 4'hF, 4'h0, 4'h4,  1, 0, 4'hF, 0, 0);
        add(0, 4'hF, 4'hF, 4'h0,  1, 1, 4'hF, 0, 0); // ->DENIED
        add(0, 4'hF, 4'hF, 4'h0,  1, 1, 4'hF, 0, 0);
        add(1, 4'hF, 4'hF, 4'h0,  1, 0, 4'hF, 0, 0); // ->RUN
        add(0, 4'h5, 4'hF, 4'h0,  1, 0, 4'hA, 0, 0); // partial enable ->REQ
        add(0, 4'hF, 4'hA, 4'h0,  0, 0, 4'hA, 0, 0); // ->STOPPED
        add(1, 4'hF, 4'hA, 4'h0,  0, 0, 4'hA, 1, 0);
        add(1, 4'hF, 4'hA, 4'h0,  0, 0, 4'hA, 1, 0);
        add(1, 4'hF, 4'hA, 4'h0,  0, 0, 4'hF, 0, 0); // ->EXIT
        add(1, 4'hF, 4'hA, 4'h0,  0, 0, 4'hF, 0, 0); // enabled still accepting
        add(1, 4'hF, 4'hF, 4'h0,  1, 0, 4'hF, 0, 0); // ->RUN
        add(0, 4'h0, 4'hF, 4'h0,  1, 0, 4'hF, 0, 0); // empty enable ->REQ
        add(0, 4'hF, 4'hF, 4'h0,  0, 0, 4'hF, 0, 0); // ->STOPPED in one cycle
        add(1, 4'hF, 4'hF, 4'h0,  0, 0, 4'hF, 1, 0);
        add(1, 4'hF, 4'hF, 4'h0,  0, 0, 4'hF, 1, 0);
        add(1, 4'hF, 4'hF, 4'h0,  0, 0, 4'hF, 0, 0); // EXIT
        add(1, 4'hF, 4'hF, 4'h0,  1, 0, 4'hF, 0, 0); // ->RUN in one cycle

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].qreqn, vecs[i].en, vecs[i].acc, vecs[i].dn);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].qa, vecs[i].qd, vecs[i].dq, vecs[i].pr, vecs[i].to);
        end

        // Timeout: device 1 never answers
        drive(1'b0, 4'hF, 4'h2, 4'h0);
        tick();
        check_all("to.entry", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            tick();
            check_all($sformatf("to.cyc%0d", k), 1'b1, 1'b0, (k == TO) ? 4'hF : 4'h0, 1'b0, (k == TO));
        end
        tick();
        check_all("to.after", 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        drive(1'b0, 4'hF, 4'hF, 4'h0);
        tick();
        check_all("to.denied", 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        drive(1'b1, 4'hF, 4'hF, 4'h0);
        tick();
        check_all("to.run", 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);

        // Reset while STOPPED
        drive(1'b0, 4'hF, 4'h0, 4'h0);
        tick(); tick();
        check_all("rst1.stopped", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all("rst1.async", 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        drive(1'b1, 4'hF, 4'hF, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while RESTORE
        drive(1'b0, 4'hF, 4'h0, 4'h0);
        tick(); tick();
        drive(1'b1, 4'hF, 4'h0, 4'h0);
        tick();
        check_all("rst2.restore", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all("rst2.async", 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        drive(1'b1, 4'hF, 4'hF, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        do_reset();
        m_phase = P_RUN; m_en = 4'h0; m_age = 0; m_left = 0; m_to = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            case (m_phase)
                P_RUN:         q = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                P_REQ, P_RB:   q = 1'b0;
                P_STOP, P_DEN: q = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
                default:       q = 1'b1;
            endcase
            for (int b = 0; b < N_CH; b++) begin
                if (m_phase == P_REQ) begin
                    acc[b] = ($urandom_range(0, 2) == 0);
                    dn[b]  = ($urandom_range(0, 31) == 0);
                end else begin
                    acc[b] = ($urandom_range(0, 3) != 0);
                    dn[b]  = ($urandom_range(0, 15) == 0);
                end
            end
            drive(q, 4'($urandom_range(0, 15)), acc, dn);
            @(posedge clk);
            model_step();
            #1;
            check_all($sformatf("rnd%0d", c),
                      !(m_phase == P_STOP || m_phase == P_RES || m_phase == P_EXIT),
                      (m_phase == P_DEN),
                      (m_phase == P_REQ || m_phase == P_STOP || m_phase == P_RES) ? ~m_en : 4'hF,
                      (m_phase == P_RES),
                      m_to);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qchannel_fanout.md
QCHANNEL_FANOUT -- requirements
Module: qchannel_fanout

Interface
REQ-001 Parameter N_CH, default 4: number of downstream device Q-channels, range 1..16.
REQ-002 Parameter RESTORE_CYCLES, default 2: pr_restore_o pulse width in cycles, range 1..15.
REQ-003 Parameter TIMEOUT, default 64: max cycles to collect downstream accepts before forced deny; 0 disables the timeout.
REQ-004 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-005 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 qreqn_i  in  1  upstream quiescence request, active-low.
REQ-007 qacceptn_o  out  1  upstream accept, active-low.
REQ-008 qdeny_o  out  1  upstream deny.
REQ-009 ch_en_i  in  N_CH  channel enable, sampled only on RUN->REQ; disabled channels are treated as always-accepting.
REQ-010 dev_qreqn_o  out  N_CH  per-device request, active-low.
REQ-011 dev_qacceptn_i  in  N_CH  per-device accept, active-low.
REQ-012 dev_qdeny_i  in  N_CH  per-device deny.
REQ-013 pr_restore_o  out  1  retention restore strobe to all devices.
REQ-014 timeout_o  out  1  one-cycle pulse when the timeout forces a deny.

Function
REQ-015 States: RUN, REQ, STOPPED, RESTORE, EXIT, ROLLBACK, DENIED.
REQ-016 RUN: qacceptn_o=1, qdeny_o=0, dev_qreqn_o all 1; on qreqn_i=0 latch ch_en_i into en_q, go to REQ.
REQ-017 REQ: dev_qreqn_o[i]=0 for i in en_q, 1 otherwise; timeout counter increments each cycle.
REQ-018 REQ->STOPPED when every enabled channel has dev_qacceptn_i=0 and dev_qdeny_i=0; qacceptn_o falls in the cycle after the condition is seen.
REQ-019 REQ->ROLLBACK when any enabled channel has dev_qdeny_i=1, or the counter reaches TIMEOUT (TIMEOUT>0); deny takes priority over all-accept in the same cycle.
REQ-020 timeout_o pulses for one cycle on the REQ->ROLLBACK edge caused by timeout only.
REQ-021 ROLLBACK: dev_qreqn_o all 1; go to DENIED when every enabled channel shows dev_qacceptn_i=1 and dev_qdeny_i=0.
REQ-022 DENIED: qdeny_o=1, qacceptn_o=1; on qreqn_i=1 go to RUN, qdeny_o falls the following cycle.
REQ-023 STOPPED: qacceptn_o=0, dev_qreqn_o for enabled channels held 0; on qreqn_i=1 go to RESTORE.
REQ-024 RESTORE: pr_restore_o=1 for exactly RESTORE_CYCLES cycles, dev_qreqn_o unchanged; then EXIT.
REQ-025 EXIT: dev_qreqn_o all 1; go to RUN when every enabled channel has dev_qacceptn_i=1; qacceptn_o rises on entry to RUN.
REQ-026 Upstream outputs obey: qacceptn_o falls only while qreqn_i=0 and qdeny_o=0; qdeny_o rises only while qreqn_i=0 and qacceptn_o=1.
REQ-027 en_q all zero: REQ->STOPPED after one cycle; EXIT->RUN after one cycle.
REQ-028 qreqn_i rising while in REQ is a protocol violation; the block is not required to handle it.
REQ-029 Timeout counter is 1 bit wider than needed for TIMEOUT, cleared on REQ entry, and saturates.
REQ-030 All outputs are registered; no combinational input-to-output path.

Reset
REQ-031 While wb_rst_ni=0: state RUN, qacceptn_o=1, qdeny_o=0, dev_qreqn_o all 1, pr_restore_o=0, timeout_o=0, counters 0, en_q 0.
REQ-032 Reset mid-sequence (any state) returns to the REQ-031 values immediately; there is no downstream handshake on reset.
REQ-033 Deassertion is synchronised externally; internally the block uses only asynchronous assert.

Structure
REQ-034 Shared package qch_pkg holds the state enum typedef qch_state_e and the N_CH maximum constant.
REQ-035 One sub-module, qch_status_agg: masked reduction of dev_qacceptn_i/dev_qdeny_i into all_accepted, all_running and any_deny.

Verification
REQ-036 N_CH=4, ch_en_i=4'hF, devices accept after 3 cycles -> qacceptn_o=0 within 5 cycles of qreqn_i falling; qdeny_o stays 0.
REQ-037 Device 2 asserts qdeny -> ROLLBACK; all dev_qreqn_o=1; qdeny_o=1 once all channels run again; clears one cycle after qreqn_i rises.
REQ-038 TIMEOUT=8, device 1 never responds -> timeout_o pulses in cycle 8 after REQ entry, followed by the REQ-037 deny sequence.
REQ-039 From STOPPED, qreqn_i rises -> pr_restore_o high exactly 2 cycles, then dev_qreqn_o=1, then qacceptn_o=1 after devices accept.
REQ-040 ch_en_i=4'b0101, channels 1 and 3 never accept -> STOPPED reached; dev_qreqn_o[1] and dev_qreqn_o[3] stay 1.
REQ-041 wb_rst_ni pulsed low in STOPPED and in RESTORE -> all outputs take the REQ-031 values in the same cycle.
